// File: rtl/rle_dec.sv
// Run-length decoder: expands rle_enc sample/count words into one output word per sample.
// Optional handshake counter port sto_cnt is enabled by defining RLE_DEC_CNT_EN.
module rle_dec #(
    parameter int unsigned DW = 32,
    parameter int unsigned KW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          clear,
    input  logic [KW-1:0] disabledGroups,
    input  logic [DW-1:0] sti_data,
    input  logic          sti_valid,
    output logic          sti_ready,
    output logic [DW-1:0] sto_data,
    output logic          sto_valid,
    input  logic          sto_ready,
    output logic          err_orphan
`ifdef RLE_DEC_CNT_EN
    ,
    output logic [31:0]   sto_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] rep_cnt_q, rep_cnt_d;
    logic [DW-1:0] held_q, held_d;
    logic [DW-1:0] sto_data_q, sto_data_d;
    logic          sto_valid_q, sto_valid_d;
    logic          err_q, err_d;

    logic [DW-1:0] data_mask;
    logic [DW-1:0] flag_mask;
    logic [DW-1:0] in_val;
    logic [DW-1:0] in_cnt;
    logic          is_cnt;
    logic          all_dis;
    logic          slot;

    // Enabled lanes are contiguous from lane 0, so the flag is the top set bit of data_mask.
    always_comb begin
        all_dis = &disabledGroups;
        data_mask = '0;
        for (int i = 0; i < int'(KW); i++) begin
            data_mask[8*i +: 8] = {8{all_dis | ~disabledGroups[i]}};
        end
        flag_mask = data_mask & ~(data_mask >> 1);
        is_cnt    = |(sti_data & flag_mask);
        in_val    = sti_data & data_mask;
        in_cnt    = in_val & ~flag_mask;
    end

    always_comb begin
        slot        = ~sto_valid_q | sto_ready;
        state_d     = state_q;
        rep_cnt_d   = rep_cnt_q;
        held_d      = held_q;
        sto_data_d  = sto_data_q;
        sto_valid_d = sto_valid_q & ~sto_ready;
        err_d       = err_q;
        sti_ready   = 1'b0;

        if (clear) begin
            state_d     = StIdle;
            rep_cnt_d   = '0;
            sto_valid_d = 1'b0;
        end else if (state_q == StRepeat) begin
            // A run in progress ignores enable and finishes.
            if (slot) begin
                sto_valid_d = 1'b1;
                sto_data_d  = held_q;
                rep_cnt_d   = rep_cnt_q - DW'(1);
                if (rep_cnt_q == DW'(1)) begin
                    state_d = StHold;
                end
            end
        end else begin
            sti_ready = slot;
            if (!enable) begin
                // Bypass copies the raw word, flag and disabled lanes included.
                state_d = StIdle;
                if (sti_valid && slot) begin
                    sto_valid_d = 1'b1;
                    sto_data_d  = sti_data;
                end
            end else if (sti_valid && slot) begin
                if (!is_cnt) begin
                    sto_valid_d = 1'b1;
                    sto_data_d  = in_val;
                    held_d      = in_val;
                    state_d     = StHold;
                end else if (state_q == StIdle) begin
                    err_d = 1'b1;
                end else if (in_cnt != '0) begin
                    rep_cnt_d = in_cnt;
                    state_d   = StRepeat;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rep_cnt_q   <= '0;
            held_q      <= '0;
            sto_data_q  <= '0;
            sto_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_cnt_q   <= rep_cnt_d;
            held_q      <= held_d;
            sto_data_q  <= sto_data_d;
            sto_valid_q <= sto_valid_d;
            err_q       <= err_d;
        end
    end

    assign sto_data   = sto_data_q;
    assign sto_valid  = sto_valid_q;
    assign err_orphan = err_q;

`ifdef RLE_DEC_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (sto_valid_q && sto_ready) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sto_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rle_dec.sv
// Scoreboard bench for rle_dec: a word-level reference model fills an expected queue on each
// accepted input; an independent monitor compares every output handshake against it.
module tb_rle_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [3:0]  dg;
    logic [31:0] sti_data;
    logic        sti_valid;
    logic        sti_ready;
    logic [31:0] sto_data;
    logic        sto_valid;
    logic        sto_ready;
    logic        err_orphan;
`ifdef RLE_DEC_CNT_EN
    logic [31:0] sto_cnt;
`endif

    rle_dec dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .clear          (clear),
        .disabledGroups (dg),
        .sti_data       (sti_data),
        .sti_valid      (sti_valid),
        .sti_ready      (sti_ready),
        .sto_data       (sto_data),
        .sto_valid      (sto_valid),
        .sto_ready      (sto_ready),
        .err_orphan     (err_orphan)
`ifdef RLE_DEC_CNT_EN
        ,
        .sto_cnt        (sto_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          hs_cnt = 0;
    int          ready_mode = 0;
    logic [31:0] exp_q[$];
    bit          model_held = 0;
    logic [31:0] model_val = '0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic int width_of(input logic [3:0] d);
        int nz = 0;
        for (int i = 0; i < 4; i++) if (!d[i]) nz++;
        return (nz == 0) ? 32 : 8 * nz;
    endfunction

    function automatic logic [31:0] mask_of(input int wb);
        logic [31:0] one = 32'd1;
        return (wb == 32) ? 32'hFFFF_FFFF : ((one << wb) - 32'd1);
    endfunction

    // Word-level reference: what the decoder must emit for an accepted word.
    function automatic void model_accept(input logic [31:0] w, input logic en);
        int          wb = width_of(dg);
        logic [31:0] mask = mask_of(wb);
        logic [31:0] n;
        if (!en) begin
            exp_q.push_back(w);
            model_held = 0;
            return;
        end
        if (!w[wb-1]) begin
            model_val  = w & mask;
            model_held = 1;
            exp_q.push_back(model_val);
        end else if (model_held) begin
            n = w & (mask >> 1);
            for (int k = 0; k < int'(n); k++) exp_q.push_back(model_val);
        end
    endfunction

    always @(negedge clk) begin
        case (ready_mode)
            0:       sto_ready = 1'b1;
            1:       sto_ready = ~sto_ready;
            default: sto_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: one cycle slot before the edge on which a handshake completes.
    always @(negedge clk) begin
        #4;
        if (!rst && sto_valid && sto_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%08h, expected no output", sto_data);
            end else begin
                check("sto_data", sto_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic en);
        bit done = 0;
        @(negedge clk);
        sti_data  = w;
        sti_valid = 1'b1;
        enable    = en;
        for (int c = 0; c < 2000 && !done; c++) begin
            #4;
            if (sti_ready) begin
                model_accept(w, en);
                done = 1;
            end
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept, expected accept of 0x%08h", w);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        sti_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !sto_valid) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        #1 check("sti_ready_in_clear", 32'(sti_ready), 32'd0);
        @(posedge clk);
        #1 check("sto_valid_after_clear", 32'(sto_valid), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        exp_q.delete();
        model_held = 0;
        hs_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          h0;
        int          wb;
        logic [31:0] w;
        logic [31:0] mask;
        logic [3:0]  dg_tab [4];
        bit          done;
        dg_tab[0] = 4'b1110; dg_tab[1] = 4'b1100; dg_tab[2] = 4'b1000; dg_tab[3] = 4'b0000;

        rst = 1'b1; enable = 1'b0; clear = 1'b0; dg = 4'b1110;
        sti_data = '0; sti_valid = 1'b0; sto_ready = 1'b1;
        #12;
        check("rst_sto_data", sto_data, 32'd0);
        check("rst_sto_valid", 32'(sto_valid), 32'd0);
        check("rst_err", 32'(err_orphan), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_sti_ready", 32'(sti_ready), 32'd1);

        // Bypass, raw words.
        send(32'h0000_0000, 1'b0); send(32'h0101_0101, 1'b0);
        send(32'h0202_0202, 1'b0); send(32'h0303_0303, 1'b0);
        idle_in(); drain();
        check("t1_count", 32'(hs_cnt), 32'd4);

        // 8-bit decode.
        h0 = hs_cnt;
        send(32'h41, 1'b1); send(32'h83, 1'b1); send(32'h42, 1'b1);
        idle_in(); drain();
        check("t2_count", 32'(hs_cnt - h0), 32'd5);
        check("t2_err", 32'(err_orphan), 32'd0);
`ifdef RLE_DEC_CNT_EN
        check("t2_sto_cnt", sto_cnt, 32'(hs_cnt));
`endif

        // Orphan count.
        do_clear();
        send(32'h85, 1'b1); idle_in();
        repeat (4) @(negedge clk);
        check("t3_err", 32'(err_orphan), 32'd1);
        check("t3_no_out", 32'(sto_valid), 32'd0);
        send(32'h43, 1'b1); idle_in(); drain();
        check("t3_count", 32'(hs_cnt), 32'd1);

        // Accumulating counts under toggling backpressure.
        ready_mode = 1;
        h0 = hs_cnt;
        send(32'h44, 1'b1); send(32'h80, 1'b1); send(32'h82, 1'b1); send(32'h81, 1'b1);
        idle_in(); drain();
        check("t4_count", 32'(hs_cnt - h0), 32'd4);
        ready_mode = 0;

        // 16-bit mode with garbage in disabled lanes.
        do_clear();
        dg = 4'b1100;
        send(32'hFFFF_1234, 1'b1); send(32'hFFFF_8003, 1'b1);
        idle_in(); drain();
        check("t5_count", 32'(hs_cnt), 32'd4);
        check("t5_err_sticky", 32'(err_orphan), 32'd1);

        // Randomised runs across lane widths, backpressure and bypass.
        for (int r = 0; r < 4; r++) begin
            do_clear();
            dg = dg_tab[$urandom_range(0, 3)];
            ready_mode = 2;
            wb = width_of(dg);
            mask = mask_of(wb);
            for (int i = 0; i < 30; i++) begin
                w = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    w = (w & ~mask) | (32'd1 << (wb - 1)) | 32'($urandom_range(0, 5));
                end else begin
                    w[wb-1] = 1'b0;
                end
                send(w, ($urandom_range(0, 7) != 0));
            end
            idle_in(); drain();
        end
        ready_mode = 0;

        // Reset in the middle of a long run.
        do_clear();
        dg = 4'b1110;
        h0 = hs_cnt;
        send(32'h46, 1'b1); send(32'hFF, 1'b1); idle_in();
        done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (hs_cnt - h0 >= 11) done = 1;
        end
        check("t6_reached_10th", 32'(done), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_valid_in_rst", 32'(sto_valid), 32'd0);
        check("t6_err_in_rst", 32'(err_orphan), 32'd0);
        check("t6_ready_in_rst", 32'(sti_ready), 32'd1);
        exp_q.delete();
        model_held = 0;
        @(negedge clk);
        rst = 1'b0;
        hs_cnt = 0;
        send(32'h85, 1'b1); idle_in();
        repeat (3) @(negedge clk);
        check("t6_idle_orphan", 32'(err_orphan), 32'd1);
        send(32'h47, 1'b1); idle_in(); drain();
        check("t6_count", 32'(hs_cnt), 32'd1);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
